// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared state encoding and default widths for freq_meter.
// Imported by freq_meter and sync_edge.
package freq_meter_pkg;

    localparam int CNT_W_DEF       = 32;
    localparam int GATE_W_DEF      = 32;
    localparam int SYNC_STAGES_DEF = 2;

    localparam int AVG_WINDOWS = 4;
    localparam int AVG_IDX_W   = 2;
    localparam logic [AVG_IDX_W-1:0] AVG_IDX_LAST = AVG_IDX_W'(AVG_WINDOWS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_GATE = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-flop synchronizer for an asynchronous input plus a
// history flop producing a one-cycle rising-edge strobe.
module sync_edge
    import freq_meter_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_hist <= w_sync;
        end
    end

    assign o_rise = w_sync & ~r_hist;

endmodule

// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of in_f over a gate of gate_len clk cycles.
// Define FREQ_METER_AVG_EN to publish the truncated mean of four windows.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int GATE_W      = GATE_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_f,
    input  logic              start,
    input  logic              cont,
    input  logic [GATE_W-1:0] gate_len,
    output logic [CNT_W-1:0]  count,
    output logic              valid,
    output logic              busy,
    output logic              ovf
);

    state_t r_state;
    state_t w_state_nxt;

    logic [GATE_W-1:0] r_gl;
    logic [GATE_W-1:0] r_gcnt;
    logic [CNT_W-1:0]  r_ecnt;
    logic              r_sat;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf;

    logic              w_rise;
    logic [GATE_W-1:0] w_gl_in;
    logic              w_last;
    logic              w_ecnt_max;
    logic [CNT_W-1:0]  w_ecnt_nxt;
    logic              w_sat_nxt;
    logic              w_load;
    logic              w_finish;
    logic              w_publish;
    logic              w_rearm;

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk    (clk),
        .rst    (rst),
        .i_async(in_f),
        .o_rise (w_rise)
    );

    // A zero gate would never terminate; treat it as a one-cycle gate.
    assign w_gl_in    = (gate_len == '0) ? GATE_W'(1) : gate_len;
    assign w_last     = (r_gcnt == (r_gl - GATE_W'(1)));
    assign w_ecnt_max = &r_ecnt;
    assign w_ecnt_nxt = (w_rise && !w_ecnt_max) ? (r_ecnt + CNT_W'(1)) : r_ecnt;
    assign w_sat_nxt  = r_sat | (w_rise & w_ecnt_max);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_finish    = 1'b0;
        busy        = 1'b0;
        valid       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                busy        = 1'b1;
                w_state_nxt = ST_GATE;
            end
            ST_GATE: begin
                busy = 1'b1;
                if (w_last) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                valid = w_publish;
                if (w_rearm) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_ARM;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_gl    <= '0;
            r_gcnt  <= '0;
            r_ecnt  <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_gl   <= w_gl_in;
                r_gcnt <= '0;
                r_ecnt <= '0;
                r_sat  <= 1'b0;
            end else if (r_state == ST_GATE) begin
                r_gcnt <= r_gcnt + GATE_W'(1);
                r_ecnt <= w_ecnt_nxt;
                r_sat  <= w_sat_nxt;
            end
        end
    end

`ifdef FREQ_METER_AVG_EN
    logic [CNT_W+1:0]     r_acc;
    logic [AVG_IDX_W-1:0] r_widx;
    logic                 r_aovf;
    logic                 r_final;
    logic [CNT_W+1:0]     w_acc_sum;
    logic                 w_win_last;

    assign w_acc_sum  = r_acc + {2'b00, w_ecnt_nxt};
    assign w_win_last = (r_widx == AVG_IDX_LAST);
    assign w_publish  = r_final;
    // Intermediate windows always re-arm; cont only matters after the last.
    assign w_rearm    = cont | ~r_final;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_widx  <= '0;
            r_aovf  <= 1'b0;
            r_final <= 1'b0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (r_state == ST_IDLE && start) begin
            r_acc   <= '0;
            r_widx  <= '0;
            r_aovf  <= 1'b0;
            r_final <= 1'b0;
        end else if (w_finish) begin
            if (w_win_last) begin
                r_count <= w_acc_sum[CNT_W+1:2];
                r_ovf   <= r_aovf | w_sat_nxt;
                r_acc   <= '0;
                r_widx  <= '0;
                r_aovf  <= 1'b0;
                r_final <= 1'b1;
            end else begin
                r_acc   <= w_acc_sum;
                r_widx  <= r_widx + AVG_IDX_W'(1);
                r_aovf  <= r_aovf | w_sat_nxt;
                r_final <= 1'b0;
            end
        end
    end
`else
    assign w_publish = 1'b1;
    assign w_rearm   = cont;

    // Result includes the final gate cycle's edge, visible during DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (w_finish) begin
            r_count <= w_ecnt_nxt;
            r_ovf   <= w_sat_nxt;
        end
    end
`endif

    assign count = r_count;
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: directed vector table plus hand-written sequences
// for reset, continuous mode and averaging.
module tb_freq_meter;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        in_f     = 1'b0;
    logic        start    = 1'b0;
    logic        start8   = 1'b0;
    logic        cont     = 1'b0;
    logic [31:0] gate_len = 32'd0;

    logic [31:0] count;
    logic        valid;
    logic        busy;
    logic        ovf;
    logic [7:0]  count8;
    logic        valid8;
    logic        busy8;
    logic        ovf8;

    freq_meter u_dut (
        .clk     (clk),
        .rst     (rst),
        .in_f    (in_f),
        .start   (start),
        .cont    (cont),
        .gate_len(gate_len),
        .count   (count),
        .valid   (valid),
        .busy    (busy),
        .ovf     (ovf)
    );

    freq_meter #(
        .CNT_W(8)
    ) u_dut8 (
        .clk     (clk),
        .rst     (rst),
        .in_f    (in_f),
        .start   (start8),
        .cont    (cont),
        .gate_len(gate_len),
        .count   (count8),
        .valid   (valid8),
        .busy    (busy8),
        .ovf     (ovf8)
    );

    always #5 clk = ~clk;

    // in_f source: square wave of period 2*half clk, or held level if half==0.
    int   half     = 0;
    logic hold_lvl = 1'b1;
    int   pcnt     = 0;

    always @(negedge clk) begin
        if (half == 0) begin
            in_f = hold_lvl;
            pcnt = 0;
        end else begin
            pcnt = pcnt + 1;
            if (pcnt >= half) begin
                in_f = ~in_f;
                pcnt = 0;
            end
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_start(input bit use8);
        @(negedge clk);
        if (use8) start8 = 1'b1;
        else start = 1'b1;
    endtask

    // Waits (bounded) for the next valid; lat counts clk edges from the call.
    task automatic wait_valid(input bit use8, input int chg_at,
                              input logic [31:0] chg_val,
                              input int restart_at, output int lat,
                              output int busyc, output logic [31:0] c,
                              output logic o);
        lat   = 0;
        busyc = 0;
        c     = 32'hdead_beef;
        o     = 1'bx;
        while (lat < 5000) begin
            @(negedge clk);
            start  = 1'b0;
            start8 = 1'b0;
            lat++;
            if (lat == chg_at) gate_len = chg_val;
            if (lat == restart_at) begin
                if (use8) start8 = 1'b1;
                else start = 1'b1;
            end
            if (use8 ? busy8 : busy) busyc++;
            if (use8 ? valid8 : valid) begin
                c = use8 ? {24'd0, count8} : count;
                o = use8 ? ovf8 : ovf;
                break;
            end
        end
    endtask

    typedef struct {
        logic [31:0] gl;
        int          h;
        bit          use8;
        logic [31:0] exp_cnt;
        logic        exp_ovf;
        int          exp_lat;
    } vec_t;

    vec_t vt[8];

    initial begin
        int          lat;
        int          busyc;
        int          nv;
        logic [31:0] c;
        logic        o;

        vt[0] = '{32'd1000, 5, 1'b0, 32'd100, 1'b0, 1002};
        vt[1] = '{32'd100,  2, 1'b0, 32'd25,  1'b0, 102};
        vt[2] = '{32'd60,   3, 1'b0, 32'd10,  1'b0, 62};
        vt[3] = '{32'd8,    1, 1'b0, 32'd4,   1'b0, 10};
        vt[4] = '{32'd0,    0, 1'b0, 32'd0,   1'b0, 3};
        vt[5] = '{32'd510,  1, 1'b1, 32'd255, 1'b0, 512};
        vt[6] = '{32'd1000, 1, 1'b1, 32'd255, 1'b1, 1002};
        vt[7] = '{32'd512,  1, 1'b1, 32'd255, 1'b1, 514};

        repeat (3) @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_count8", count8, 0);
        rst = 1'b0;

`ifndef FREQ_METER_AVG_EN
        for (int i = 0; i < 8; i++) begin
            half     = vt[i].h;
            hold_lvl = 1'b1;
            gate_len = vt[i].gl;
            repeat (20) @(negedge clk);
            pulse_start(vt[i].use8);
            wait_valid(vt[i].use8, -1, 32'd0, -1, lat, busyc, c, o);
            chk($sformatf("v%0d_lat", i), lat, vt[i].exp_lat);
            chk($sformatf("v%0d_busy", i), busyc, vt[i].exp_lat - 1);
            chk($sformatf("v%0d_count", i), c, vt[i].exp_cnt);
            chk($sformatf("v%0d_ovf", i), o, vt[i].exp_ovf);
            @(negedge clk);
            chk($sformatf("v%0d_vdrop", i), vt[i].use8 ? valid8 : valid, 0);
        end

        // gate_len change mid-gate ignored; start while busy ignored
        half     = 5;
        gate_len = 32'd100;
        repeat (20) @(negedge clk);
        pulse_start(1'b0);
        wait_valid(1'b0, 30, 32'd7, 50, lat, busyc, c, o);
        chk("chg_lat", lat, 102);
        chk("chg_count", c, 10);
        repeat (5) @(negedge clk);
        chk("noqueue_busy", busy, 0);
        chk("count_hold", count, 10);

        // continuous mode, then drop cont mid-gate
        half     = 2;
        gate_len = 32'd100;
        cont     = 1'b1;
        repeat (20) @(negedge clk);
        pulse_start(1'b0);
        wait_valid(1'b0, -1, 32'd0, -1, lat, busyc, c, o);
        chk("cont1_lat", lat, 102);
        chk("cont1_count", c, 25);
        wait_valid(1'b0, -1, 32'd0, -1, lat, busyc, c, o);
        chk("cont2_lat", lat, 102);
        chk("cont2_count", c, 25);
        repeat (40) @(negedge clk);
        cont = 1'b0;
        wait_valid(1'b0, -1, 32'd0, -1, lat, busyc, c, o);
        chk("cont3_lat", lat, 62);
        chk("cont3_count", c, 25);
        nv = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (valid) nv++;
        end
        chk("cont_stop_valids", nv, 0);
        chk("cont_stop_busy", busy, 0);

        // reset mid-gate discards the measurement
        half     = 5;
        gate_len = 32'd1000;
        repeat (20) @(negedge clk);
        pulse_start(1'b0);
        repeat (50) @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_count", count, 0);
        chk("mrst_valid", valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_ovf", ovf, 0);
        nv = 0;
        for (int k = 0; k < 1100; k++) begin
            @(negedge clk);
            if (valid) nv++;
        end
        chk("mrst_no_valid", nv, 0);
        pulse_start(1'b0);
        wait_valid(1'b0, -1, 32'd0, -1, lat, busyc, c, o);
        chk("post_rst_lat", lat, 1002);
        chk("post_rst_count", c, 100);
`else
        // four windows of 100, 101, 100, 102 edges -> mean 100
        half     = 5;
        gate_len = 32'd1000;
        cont     = 1'b0;
        repeat (20) @(negedge clk);
        pulse_start(1'b0);
        nv  = 0;
        lat = 0;
        c   = 32'hdead_beef;
        o   = 1'bx;
        for (int n = 1; n <= 4200; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 500)  gate_len = 32'd1010;
            if (n == 1500) gate_len = 32'd1000;
            if (n == 2500) gate_len = 32'd1020;
            if (valid) begin
                nv++;
                lat = n;
                c   = count;
                o   = ovf;
            end
        end
        chk("avg_valids", nv, 1);
        chk("avg_lat", lat, 4038);
        chk("avg_count", c, 100);
        chk("avg_ovf", o, 0);
        chk("avg_busy_end", busy, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
